// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller in front of the Gaussian filter pipeline.
// Arms on a software start and gates the DMA input stream to exactly one frame of pixels.
// Watches the pipeline output handshake and raises a level interrupt on done or error.
//
// Ports:
//   axi_clk, axi_reset_n          clock, asynchronous active-low reset
//   i_start, i_abort, i_intr_clr  software control pulses
//   s_in_valid/s_in_data/s_in_ready   DMA input side
//   m_in_valid/m_in_data/m_in_ready   pipeline input side (gated pass-through)
//   i_out_valid/i_out_ready/i_out_last  pipeline output handshake (monitor only)
//   o_busy, o_intr, o_status      frame state; status = {missing_last, early_last, timeout}
//   o_in_count, o_out_count       beats accepted / observed this frame
module frame_sequencer #(
  parameter int unsigned IMG_WIDTH      = 512,
  parameter int unsigned IMG_HEIGHT     = 512,
  parameter int unsigned IN_PIXELS      = IMG_WIDTH * IMG_HEIGHT,
  parameter int unsigned OUT_PIXELS     = IMG_WIDTH * IMG_HEIGHT,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             axi_clk,
  input  logic             axi_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_intr_clr,
  input  logic             s_in_valid,
  input  logic [7:0]       s_in_data,
  output logic             s_in_ready,
  output logic             m_in_valid,
  output logic [7:0]       m_in_data,
  input  logic             m_in_ready,
  input  logic             i_out_valid,
  input  logic             i_out_ready,
  input  logic             i_out_last,
  output logic             o_busy,
  output logic             o_intr,
  output logic [2:0]       o_status,
  output logic [CNT_W-1:0] o_in_count,
  output logic [CNT_W-1:0] o_out_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] InPix   = CNT_W'(IN_PIXELS);
  localparam logic [CNT_W-1:0] OutLast = CNT_W'(OUT_PIXELS - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StError} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [2:0]       status_q, status_d;

  logic in_en, in_beat, out_beat, active, tmo_hit;

  // Input gating is purely combinational so the pipeline sees no extra latency.
  assign in_en      = (state_q == StRun) && (in_cnt_q < InPix);
  assign s_in_ready = m_in_ready & in_en;
  assign m_in_valid = s_in_valid & in_en;
  assign m_in_data  = s_in_data;

  assign in_beat  = m_in_valid & m_in_ready;
  assign out_beat = i_out_valid & i_out_ready;
  assign active   = (state_q == StRun) || (state_q == StDrain);
  // Idle cycle that would bring the timeout counter to TIMEOUT_CYCLES.
  assign tmo_hit  = active && !in_beat && !out_beat && (tmo_q == TmoLast);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    status_d  = status_q;
    tmo_d     = '0;

    if (active) begin
      if (in_beat && (in_cnt_q != CntMax)) in_cnt_d = in_cnt_q + 1'b1;
      if (out_beat && (out_cnt_q != CntMax)) out_cnt_d = out_cnt_q + 1'b1;
      tmo_d = (in_beat || out_beat) ? '0 : tmo_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d   = StRun;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          status_d  = '0;
        end
      end
      StRun: begin
        if (out_beat && i_out_last) begin
          state_d     = StError;
          status_d[1] = 1'b1;
        end else if (tmo_hit) begin
          state_d     = StError;
          status_d[0] = 1'b1;
        end else if (in_beat && (in_cnt_d == InPix)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_beat) begin
          // Decisions use the pre-increment count of the beat being observed.
          if (out_cnt_q >= OutLast) begin
            if (i_out_last) begin
              state_d = StDone;
            end else begin
              state_d     = StError;
              status_d[2] = 1'b1;
            end
          end else if (i_out_last) begin
            state_d     = StError;
            status_d[1] = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d     = StError;
          status_d[0] = 1'b1;
        end
      end
      StDone, StError: begin
        if (i_intr_clr) begin
          state_d  = StIdle;
          status_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything: back to idle, counters and flags left for software to inspect.
    if (i_abort) begin
      state_d   = StIdle;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      status_d  = status_q;
    end

    if ((state_d != StRun) && (state_d != StDrain)) tmo_d = '0;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tmo_q     <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      tmo_q     <= tmo_d;
      status_q  <= status_d;
    end
  end

  assign o_busy      = active;
  assign o_intr      = (state_q == StDone) || (state_q == StError);
  assign o_status    = status_q;
  assign o_in_count  = in_cnt_q;
  assign o_out_count = out_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int PIX = W * H;
  localparam int TMO = 100;
  localparam int CW = 20;

  logic          axi_clk, axi_reset_n;
  logic          i_start, i_abort, i_intr_clr;
  logic          s_in_valid, s_in_ready, m_in_valid, m_in_ready;
  logic [7:0]    s_in_data, m_in_data;
  logic          i_out_valid, i_out_ready, i_out_last;
  logic          o_busy, o_intr;
  logic [2:0]    o_status;
  logic [CW-1:0] o_in_count, o_out_count;

  int n_checks = 0;
  int n_errors = 0;
  int model_in = 0;  // beats the DMA has handed over this frame

  frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .i_start(i_start), .i_abort(i_abort), .i_intr_clr(i_intr_clr),
    .s_in_valid(s_in_valid), .s_in_data(s_in_data), .s_in_ready(s_in_ready),
    .m_in_valid(m_in_valid), .m_in_data(m_in_data), .m_in_ready(m_in_ready),
    .i_out_valid(i_out_valid), .i_out_ready(i_out_ready), .i_out_last(i_out_last),
    .o_busy(o_busy), .o_intr(o_intr), .o_status(o_status),
    .o_in_count(o_in_count), .o_out_count(o_out_count)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start = 0; i_abort = 0; i_intr_clr = 0;
    s_in_valid = 0; s_in_data = 8'h00; m_in_ready = 0;
    i_out_valid = 0; i_out_ready = 0; i_out_last = 0;
  endtask

  task automatic pulse_start();
    i_start = 1; tick(); i_start = 0;
    model_in = 0;
  endtask

  task automatic pulse_abort();
    i_abort = 1; tick(); i_abort = 0;
  endtask

  task automatic pulse_clr();
    i_intr_clr = 1; tick(); i_intr_clr = 0;
  endtask

  // DMA offers beats until `target` are taken, then `extra` more that must be refused.
  task automatic feed_inputs(input int target, input int extra, input bit rnd);
    int cyc = 0;
    bit exp_en;
    while (model_in < target && cyc < 2000) begin
      s_in_valid = 1;
      m_in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_in_data  = 8'($urandom);
      #2;
      exp_en = (model_in < PIX);
      chk("s_in_ready", int'(s_in_ready), int'(exp_en & m_in_ready));
      chk("m_in_valid", int'(m_in_valid), int'(exp_en));
      chk("m_in_data", int'(m_in_data), int'(s_in_data));
      if (exp_en && m_in_ready) model_in++;
      cyc++;
      tick();
    end
    chk("in_budget", model_in, target);
    for (int i = 0; i < extra; i++) begin
      s_in_valid = 1; m_in_ready = 1; s_in_data = 8'($urandom);
      #2;
      exp_en = (model_in < PIX);
      chk("s_in_ready_gate", int'(s_in_ready), int'(exp_en));
      chk("m_in_valid_gate", int'(m_in_valid), int'(exp_en));
      if (exp_en) model_in++;
      tick();
    end
    s_in_valid = 0; m_in_ready = 0;
  endtask

  // n output beats, TLAST on beat last_at (0 = never), random non-beat gaps before each.
  task automatic feed_outputs(input int n, input int last_at);
    for (int k = 1; k <= n; k++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        int r = $urandom_range(0, 2);
        i_out_valid = (r == 1);
        i_out_ready = (r == 2);
        i_out_last  = 1'($urandom_range(0, 1));
        tick();
      end
      i_out_valid = 1; i_out_ready = 1; i_out_last = (k == last_at);
      tick();
    end
    i_out_valid = 0; i_out_ready = 0; i_out_last = 0;
  endtask

  // Frame outcome from the output-beat rules alone (all input already taken).
  task automatic frame_outcome(input int n, input int last_at,
                               output bit fin, output int st, output int cnt);
    if (last_at >= 1 && last_at <= n && last_at < PIX) begin
      fin = 1; st = 3'b010; cnt = last_at;
    end else if (n >= PIX) begin
      fin = 1; cnt = PIX;
      st = (last_at == PIX) ? 3'b000 : 3'b100;
    end else begin
      fin = 0; st = 0; cnt = n;
    end
  endtask

  task automatic check_frame(input string tag, input int n, input int last_at);
    bit fin; int st; int cnt;
    frame_outcome(n, last_at, fin, st, cnt);
    chk({tag, "_intr"}, int'(o_intr), int'(fin));
    chk({tag, "_busy"}, int'(o_busy), int'(!fin));
    chk({tag, "_status"}, int'(o_status), st);
    chk({tag, "_in_count"}, int'(o_in_count), PIX);
    chk({tag, "_out_count"}, int'(o_out_count), cnt);
  endtask

  typedef struct {
    bit start, abort, clr, sv, mr;
    bit exp_sready, exp_busy, exp_intr;
    int exp_in;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};  // idle: gated
    tbl[1] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};  // start arms
    tbl[2] = '{0, 0, 0, 1, 1, 1, 1, 0, 1};  // one beat accepted
    tbl[3] = '{1, 0, 0, 1, 0, 0, 1, 0, 1};  // start in RUN ignored
    tbl[4] = '{0, 0, 0, 0, 1, 1, 1, 0, 1};  // ready follows m_in_ready
    tbl[5] = '{0, 1, 0, 0, 1, 1, 0, 0, 1};  // abort: idle, count held
    tbl[6] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};  // clr in idle harmless
    tbl[7] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};  // restart clears count
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};  // abort again

    idle_inputs();
    axi_reset_n = 0;
    repeat (3) tick();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_intr", int'(o_intr), 0);
    chk("rst_status", int'(o_status), 0);
    chk("rst_in_count", int'(o_in_count), 0);
    chk("rst_out_count", int'(o_out_count), 0);
    axi_reset_n = 1;
    tick();

    // Control table
    foreach (tbl[i]) begin
      i_start = tbl[i].start; i_abort = tbl[i].abort; i_intr_clr = tbl[i].clr;
      s_in_valid = tbl[i].sv; m_in_ready = tbl[i].mr; s_in_data = 8'($urandom);
      #2;
      chk($sformatf("tbl%0d_sready", i), int'(s_in_ready), int'(tbl[i].exp_sready));
      tick();
      chk($sformatf("tbl%0d_busy", i), int'(o_busy), int'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_intr", i), int'(o_intr), int'(tbl[i].exp_intr));
      chk($sformatf("tbl%0d_in", i), int'(o_in_count), tbl[i].exp_in);
    end
    idle_inputs();
    tick();

    // 1: full good frame, random input backpressure
    pulse_start();
    feed_inputs(PIX, 0, 1);
    s_in_valid = 1; m_in_ready = 1;
    #2;
    chk("t1_gate_after_last", int'(s_in_ready), 0);
    tick();
    s_in_valid = 0; m_in_ready = 0;
    feed_outputs(PIX, PIX);
    check_frame("t1", PIX, PIX);
    pulse_clr();
    chk("t1_clr_intr", int'(o_intr), 0);
    chk("t1_clr_busy", int'(o_busy), 0);

    // 2: DMA offers 40 beats, only 32 taken
    pulse_start();
    feed_inputs(PIX, 8, 0);
    chk("t2_in_count", int'(o_in_count), PIX);
    chk("t2_busy", int'(o_busy), 1);
    pulse_abort();

    // 3: early TLAST on beat 20, later beats ignored
    pulse_start();
    feed_inputs(PIX, 0, 0);
    feed_outputs(20, 20);
    check_frame("t3", 20, 20);
    feed_outputs(3, 0);
    chk("t3_frozen_out", int'(o_out_count), 20);
    pulse_clr();

    // 4: no TLAST at all
    pulse_start();
    feed_inputs(PIX, 0, 1);
    feed_outputs(PIX, 0);
    check_frame("t4", PIX, 0);
    pulse_clr();

    // 5: output stalls after 10 beats; 100 idle cycles trip the timeout
    pulse_start();
    feed_inputs(PIX, 0, 0);
    feed_outputs(10, 0);
    repeat (TMO - 1) tick();
    chk("t5_busy_before", int'(o_busy), 1);
    chk("t5_intr_before", int'(o_intr), 0);
    tick();
    chk("t5_intr", int'(o_intr), 1);
    chk("t5_status", int'(o_status), 3'b001);
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_out_count", int'(o_out_count), 10);
    pulse_clr();

    // 6a: abort mid-RUN at 12 inputs
    pulse_start();
    feed_inputs(12, 0, 0);
    pulse_abort();
    chk("t6_abort_busy", int'(o_busy), 0);
    chk("t6_abort_intr", int'(o_intr), 0);
    chk("t6_abort_in", int'(o_in_count), 12);
    // 6b: start during DONE ignored; clr beats start
    pulse_start();
    feed_inputs(PIX, 0, 0);
    feed_outputs(PIX, PIX);
    pulse_start();
    chk("t6_done_intr", int'(o_intr), 1);
    chk("t6_done_busy", int'(o_busy), 0);
    chk("t6_done_in", int'(o_in_count), PIX);
    i_start = 1; i_intr_clr = 1; tick(); i_start = 0; i_intr_clr = 0;
    chk("t6_clrwin_intr", int'(o_intr), 0);
    chk("t6_clrwin_busy", int'(o_busy), 0);
    tick();
    chk("t6_clrwin_idle", int'(o_busy), 0);

    // Randomized frames against the outcome model
    for (int f = 0; f < 8; f++) begin
      int last_at, n;
      case ($urandom_range(0, 3))
        0: begin last_at = PIX; n = PIX; end
        1: begin last_at = 0; n = PIX; end
        2: begin last_at = $urandom_range(1, PIX - 1); n = last_at; end
        default: begin last_at = $urandom_range(1, PIX - 1); n = last_at + 2; end
      endcase
      pulse_start();
      feed_inputs(PIX, $urandom_range(0, 3), 1);
      feed_outputs(n, last_at);
      check_frame($sformatf("rnd%0d", f), n, last_at);
      pulse_clr();
      chk($sformatf("rnd%0d_clr_status", f), int'(o_status), 0);
    end

    // 6c: asynchronous reset mid-DRAIN clears everything at once
    pulse_start();
    feed_inputs(PIX, 0, 0);
    feed_outputs(5, 0);
    s_in_valid = 1; m_in_ready = 1;
    #2;
    axi_reset_n = 0;
    #1;
    chk("t6_rst_busy", int'(o_busy), 0);
    chk("t6_rst_in", int'(o_in_count), 0);
    chk("t6_rst_out", int'(o_out_count), 0);
    chk("t6_rst_sready", int'(s_in_ready), 0);
    chk("t6_rst_mvalid", int'(m_in_valid), 0);
    idle_inputs();
    tick();
    axi_reset_n = 1;
    tick();
    chk("t6_post_rst_intr", int'(o_intr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
